// File: rtl/sc_regbus_pkg.sv
// Shared definitions for the register-bank read-bus arbiter: state encoding,
// default widths and a one-hot to index helper.
package sc_regbus_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      READ = ST_READ,
      ACK  = ST_ACK
   } arbState_t;

   localparam int DEF_DATAWIDTH_BUS = 32;
   localparam int DEF_ADDRWIDTH     = 5;
   localparam int DEF_NUM_REGS      = 32;
   localparam int DEF_NUM_REQ       = 4;
   localparam int DEF_READ_LATENCY  = 1;

   // Highest set bit wins; callers only pass one-hot or zero vectors.
   function automatic int oneHotIdx(input logic [31:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/sc_rr_picker.sv
// Combinational requester picker: round-robin scan starting at the pointer, or
// lowest-index fixed priority when SC_REGBUS_ARB_FIXEDPRI_EN is defined.
module sc_rr_picker
   import sc_regbus_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDXW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDXW-1:0]    ptr,
   output logic [NUM_REQ-1:0] winOh,
   output logic [IDXW-1:0]    winIdx,
   output logic               anyReq
);

`ifdef SC_REGBUS_ARB_FIXEDPRI_EN
   localparam bit RR_EN = 1'b0;
`else
   localparam bit RR_EN = 1'b1;
`endif

   int              start;
   logic            found;
   logic [IDXW-1:0] idx;

   always_comb begin
      winOh = '0;
      found = 1'b0;
      idx   = '0;
      start = RR_EN ? int'(ptr) : 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         idx = IDXW'((start + j) % NUM_REQ);
         if (!found && req[idx]) begin
            winOh[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign winIdx = IDXW'(oneHotIdx(32'(winOh)));
   assign anyReq = |req;

endmodule

// File: rtl/sc_regbus_arbiter.sv
// Register-bank read-bus arbiter: IDLE -> READ -> ACK FSM on the falling clock edge.
// Define SC_REGBUS_ARB_FIXEDPRI_EN for fixed priority (lowest index wins, pointer held 0).
module sc_regbus_arbiter
   import sc_regbus_pkg::*;
#(
   parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
   parameter int ADDRWIDTH     = DEF_ADDRWIDTH,
   parameter int NUM_REGS      = DEF_NUM_REGS,
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
   input  logic                         SC_RegBusArb_CLOCK_50,
   input  logic                         SC_RegFIXED_RESET_InHigh,
   input  logic [NUM_REQ-1:0]           SC_RegBusArb_req_InBUS,
   input  logic [NUM_REQ*ADDRWIDTH-1:0] SC_RegBusArb_addr_InBUS,
   input  logic [DATAWIDTH_BUS-1:0]     SC_RegBusArb_regdata_InBUS,
   output logic [NUM_REQ-1:0]           SC_RegBusArb_grant_OutBUS,
   output logic [NUM_REQ-1:0]           SC_RegBusArb_ack_OutBUS,
   output logic [DATAWIDTH_BUS-1:0]     SC_RegBusArb_data_OutBUS,
   output logic [ADDRWIDTH-1:0]         SC_RegBusArb_regsel_OutBUS,
   output logic                         SC_RegBusArb_regsel_valid_Out,
   output logic                         SC_RegBusArb_err_Out,
   output logic                         SC_RegBusArb_busy_Out
);

   localparam int IDXW = $clog2(NUM_REQ);
   localparam int CNTW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   arbState_t          state;
   logic [IDXW-1:0]    rrPtr;
   logic [IDXW-1:0]    nextPtr;
   logic [CNTW-1:0]    latCnt;
   logic               oorQ;
   logic [NUM_REQ-1:0] winOh;
   logic [IDXW-1:0]    winIdx;
   logic               anyReq;
   logic [ADDRWIDTH-1:0] addrSel;
   logic               inRange;

   sc_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IDXW)
   ) uPick (
      .req    (SC_RegBusArb_req_InBUS),
      .ptr    (rrPtr),
      .winOh  (winOh),
      .winIdx (winIdx),
      .anyReq (anyReq)
   );

   always_comb begin
      addrSel = SC_RegBusArb_addr_InBUS[int'(winIdx)*ADDRWIDTH +: ADDRWIDTH];
      inRange = int'(addrSel) < NUM_REGS;
   end

`ifdef SC_REGBUS_ARB_FIXEDPRI_EN
   assign nextPtr = '0;
`else
   logic [IDXW-1:0] ownIdx;
   assign ownIdx  = IDXW'(oneHotIdx(32'(SC_RegBusArb_grant_OutBUS)));
   assign nextPtr = (ownIdx == IDXW'(NUM_REQ-1)) ? '0 : ownIdx + 1'b1;
`endif

   always_ff @(negedge SC_RegBusArb_CLOCK_50 or posedge SC_RegFIXED_RESET_InHigh) begin
      if (SC_RegFIXED_RESET_InHigh) begin
         state                         <= IDLE;
         rrPtr                         <= '0;
         latCnt                        <= '0;
         oorQ                          <= 1'b0;
         SC_RegBusArb_grant_OutBUS     <= '0;
         SC_RegBusArb_ack_OutBUS       <= '0;
         SC_RegBusArb_data_OutBUS      <= '0;
         SC_RegBusArb_regsel_OutBUS    <= '0;
         SC_RegBusArb_regsel_valid_Out <= 1'b0;
         SC_RegBusArb_err_Out          <= 1'b0;
         SC_RegBusArb_busy_Out         <= 1'b0;
      end else begin
         SC_RegBusArb_ack_OutBUS <= '0;
         SC_RegBusArb_err_Out    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (anyReq) begin
                  state                         <= READ;
                  SC_RegBusArb_grant_OutBUS     <= winOh;
                  SC_RegBusArb_regsel_OutBUS    <= addrSel;
                  SC_RegBusArb_regsel_valid_Out <= inRange;
                  SC_RegBusArb_busy_Out         <= 1'b1;
                  oorQ                          <= !inRange;
                  latCnt                        <= CNTW'(READ_LATENCY-1);
               end
            end
            READ: begin
               if (latCnt == '0) begin
                  // Out-of-range reads never look at the bus; they return zero with err.
                  SC_RegBusArb_data_OutBUS      <= oorQ ? '0 : SC_RegBusArb_regdata_InBUS;
                  SC_RegBusArb_ack_OutBUS       <= SC_RegBusArb_grant_OutBUS;
                  SC_RegBusArb_err_Out          <= oorQ;
                  SC_RegBusArb_regsel_OutBUS    <= '0;
                  SC_RegBusArb_regsel_valid_Out <= 1'b0;
                  state                         <= ACK;
               end else begin
                  latCnt <= latCnt - 1'b1;
               end
            end
            ACK: begin
               state                     <= IDLE;
               rrPtr                     <= nextPtr;
               SC_RegBusArb_grant_OutBUS <= '0;
               SC_RegBusArb_busy_Out     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
